// File: rtl/fpu_dram_arbiter.sv
// Purpose: round-robin arbiter sharing one FPU DRAM channel between a read (fetch) and a write (writeback) requester.
// Latency: grant/dram_request one cycle after a request is taken in IDLE; done pulse one cycle after the last beat/request_done.
// Backpressure: beats move only when dram_dram_ready and the granted requester's ready/valid are both high.
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_rd_* / o_rd_*             read requester: req/addr/size in, grant/data/valid/done out, data_ready in
//   i_wr_* / o_wr_*             write requester: req/addr/size/data/valid in, grant/ready/done out
//   o_dram_* / i_dram_*         FPU side of the DRAM interface
//   o_protocol_err              sticky: DRAM finished a burst before all beats arrived
module fpu_dram_arbiter #(
  parameter int MEM_BUFFER_WIDTH = 512,
  parameter int SIZE_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_rd_req,
  input  logic [ADDR_WIDTH-1:0]       i_rd_addr,
  input  logic [SIZE_WIDTH-1:0]       i_rd_size,
  output logic                        o_rd_grant,
  output logic [MEM_BUFFER_WIDTH-1:0] o_rd_data,
  output logic                        o_rd_data_valid,
  input  logic                        i_rd_data_ready,
  output logic                        o_rd_done,
  input  logic                        i_wr_req,
  input  logic [ADDR_WIDTH-1:0]       i_wr_addr,
  input  logic [SIZE_WIDTH-1:0]       i_wr_size,
  output logic                        o_wr_grant,
  input  logic [MEM_BUFFER_WIDTH-1:0] i_wr_data,
  input  logic                        i_wr_data_valid,
  output logic                        o_wr_data_ready,
  output logic                        o_wr_done,
  output logic                        o_dram_request,
  output logic [SIZE_WIDTH-1:0]       o_dram_request_size,
  output logic [ADDR_WIDTH-1:0]       o_dram_address,
  output logic                        o_dram_rd_wr,
  output logic                        o_dram_fpu_ready,
  input  logic                        i_dram_dram_ready,
  input  logic                        i_dram_request_done,
  input  logic [MEM_BUFFER_WIDTH-1:0] i_dram_read_data,
  output logic [MEM_BUFFER_WIDTH-1:0] o_dram_write_data,
  output logic                        o_protocol_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_FIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SIZE_WIDTH-1:0] r_cnt;
  logic [SIZE_WIDTH-1:0] r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_wr;
  logic                  r_rr_wr;      // 1: write wins the next tie
  logic                  r_done_seen;
  logic                  r_rd_grant;
  logic                  r_wr_grant;
  logic                  r_rd_done;
  logic                  r_wr_done;
  logic                  r_dram_request;
  logic                  r_perr;

  logic                  w_in_xfer;
  logic                  w_cnt_full;
  logic                  w_fpu_ready;
  logic                  w_beat;
  logic [SIZE_WIDTH-1:0] w_cnt_nxt;
  logic                  w_pick_wr;
  logic [SIZE_WIDTH-1:0] w_sel_size;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_load;
  logic                  w_fin_entry;
  logic                  w_perr_set;

  // Datapath steering; beats stop once the burst count is reached so a
  // requester that keeps valid/ready high cannot sneak in an extra beat.
  assign w_in_xfer   = (r_state == S_XFER);
  assign w_cnt_full  = (r_cnt == r_size);
  assign w_fpu_ready = w_in_xfer && !w_cnt_full && (r_rd_wr ? i_wr_data_valid : i_rd_data_ready);
  assign w_beat      = w_fpu_ready && i_dram_dram_ready;
  assign w_cnt_nxt   = r_cnt + SIZE_WIDTH'(w_beat);

  assign o_dram_fpu_ready  = w_fpu_ready;
  assign o_rd_data_valid   = w_in_xfer && !r_rd_wr && !w_cnt_full && i_dram_dram_ready;
  assign o_rd_data         = i_dram_read_data;
  assign o_wr_data_ready   = w_in_xfer && r_rd_wr && !w_cnt_full && i_dram_dram_ready && i_wr_data_valid;
  assign o_dram_write_data = i_wr_data;

  // Write wins when it is the only requester, or on a tie when it is its turn.
  assign w_pick_wr  = i_wr_req && (!i_rd_req || r_rr_wr);
  assign w_sel_size = w_pick_wr ? i_wr_size : i_rd_size;
  assign w_sel_addr = w_pick_wr ? i_wr_addr : i_rd_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fin_entry = 1'b0;
    w_perr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rd_req || i_wr_req) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Zero-length bursts never touch DRAM.
        if (r_size == '0) begin
          w_fin_entry = 1'b1;
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        // Count includes this cycle's beat so a request_done coincident
        // with the last beat completes immediately and is not an error.
        if ((w_cnt_nxt == r_size) && (r_done_seen || i_dram_request_done)) begin
          w_fin_entry = 1'b1;
          w_state_nxt = S_FIN;
        end
        if (i_dram_request_done && (w_cnt_nxt != r_size)) begin
          w_perr_set = 1'b1;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_size         <= '0;
      r_addr         <= '0;
      r_rd_wr        <= 1'b0;
      r_rr_wr        <= 1'b0;
      r_done_seen    <= 1'b0;
      r_rd_grant     <= 1'b0;
      r_wr_grant     <= 1'b0;
      r_rd_done      <= 1'b0;
      r_wr_done      <= 1'b0;
      r_dram_request <= 1'b0;
      r_perr         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_dram_request <= w_load && (w_sel_size != '0);
      r_rd_done      <= w_fin_entry && !r_rd_wr;
      r_wr_done      <= w_fin_entry && r_rd_wr;
      if (w_load) begin
        r_addr      <= w_sel_addr;
        r_size      <= w_sel_size;
        r_rd_wr     <= w_pick_wr;
        r_rd_grant  <= !w_pick_wr;
        r_wr_grant  <= w_pick_wr;
        r_cnt       <= '0;
        r_done_seen <= 1'b0;
      end
      if (w_in_xfer) begin
        r_cnt <= w_cnt_nxt;
        if (i_dram_request_done) begin
          r_done_seen <= 1'b1;
        end
      end
      if (w_perr_set) begin
        r_perr <= 1'b1;
      end
      if (r_state == S_FIN) begin
        r_rd_grant <= 1'b0;
        r_wr_grant <= 1'b0;
        r_rr_wr    <= !r_rd_wr;
      end
    end
  end

  assign o_rd_grant          = r_rd_grant;
  assign o_wr_grant          = r_wr_grant;
  assign o_rd_done           = r_rd_done;
  assign o_wr_done           = r_wr_done;
  assign o_dram_request      = r_dram_request;
  assign o_dram_request_size = r_size;
  assign o_dram_address      = r_addr;
  assign o_dram_rd_wr        = r_rd_wr;
  assign o_protocol_err      = r_perr;

endmodule

// File: tb/tb_fpu_dram_arbiter.sv
// Directed bench for fpu_dram_arbiter: read/write bursts, round-robin ties,
// early request_done, zero-length burst and mid-burst reset.
module tb_fpu_dram_arbiter;
  localparam int MW = 64;
  localparam int SW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [SW-1:0] rd_size, wr_size;
  logic          rd_grant, wr_grant;
  logic [MW-1:0] rd_data;
  logic          rd_data_valid, rd_data_ready, rd_done;
  logic [MW-1:0] wr_data;
  logic          wr_data_valid, wr_data_ready, wr_done;
  logic          dram_request;
  logic [SW-1:0] dram_request_size;
  logic [AW-1:0] dram_address;
  logic          dram_rd_wr, dram_fpu_ready, dram_dram_ready, dram_request_done;
  logic [MW-1:0] dram_read_data, dram_write_data;
  logic          protocol_err;

  always #5 clk = ~clk;

  fpu_dram_arbiter #(.MEM_BUFFER_WIDTH(MW), .SIZE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_size(rd_size),
    .o_rd_grant(rd_grant), .o_rd_data(rd_data), .o_rd_data_valid(rd_data_valid),
    .i_rd_data_ready(rd_data_ready), .o_rd_done(rd_done),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_size(wr_size),
    .o_wr_grant(wr_grant), .i_wr_data(wr_data), .i_wr_data_valid(wr_data_valid),
    .o_wr_data_ready(wr_data_ready), .o_wr_done(wr_done),
    .o_dram_request(dram_request), .o_dram_request_size(dram_request_size),
    .o_dram_address(dram_address), .o_dram_rd_wr(dram_rd_wr),
    .o_dram_fpu_ready(dram_fpu_ready), .i_dram_dram_ready(dram_dram_ready),
    .i_dram_request_done(dram_request_done), .i_dram_read_data(dram_read_data),
    .o_dram_write_data(dram_write_data), .o_protocol_err(protocol_err)
  );

  int vectors = 0;
  int errs    = 0;

  // Passive monitor sampled mid-cycle, away from the active edge.
  int            rd_beats = 0, wr_beats = 0, dreq_cnt = 0, overlap = 0, stray_done = 0;
  logic [MW-1:0] rd_log[$];
  always @(negedge clk) begin
    if (rd_data_valid && rd_data_ready) begin
      rd_beats++;
      rd_log.push_back(rd_data);
    end
    if (wr_data_ready) wr_beats++;
    if (dram_request) dreq_cnt++;
    if (rd_grant && wr_grant) overlap++;
    if ((rd_done && !rd_grant) || (wr_done && !wr_grant)) stray_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int b0, d0, w0, acc, n, nr, nw, gap;
    logic exp_rdy;

    rst_n = 1'b0; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0;
    rd_size = '0; wr_size = '0; rd_data_ready = 0; wr_data = '0; wr_data_valid = 0;
    dram_dram_ready = 0; dram_request_done = 0; dram_read_data = '0;
    tick(); tick();

    // ---- reset state
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_wr_grant", wr_grant, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_dram_req", dram_request, 0);
    chk("rst_size", dram_request_size, 0);
    chk("rst_addr", dram_address, 0);
    chk("rst_rd_wr", dram_rd_wr, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_fpu_ready", dram_fpu_ready, 0);
    rst_n = 1'b1;
    tick();

    // ---- single read, size 8, random DRAM gaps
    d0 = dreq_cnt;
    rd_req = 1; rd_addr = 32'h1000; rd_size = 8; rd_data_ready = 1;
    tick();
    chk("rd_grant", rd_grant, 1);
    chk("rd_no_wr_grant", wr_grant, 0);
    chk("rd_dram_req", dram_request, 1);
    chk("rd_req_size", dram_request_size, 8);
    chk("rd_req_addr", dram_address, 32'h1000);
    chk("rd_rd_wr", dram_rd_wr, 0);
    tick();
    chk("rd_req_oneshot", dram_request, 0);
    b0 = rd_beats;
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, 10));
      repeat (gap) tick();
      dram_read_data = 64'hA000 + 64'(i);
      dram_dram_ready = 1;
      tick();
      dram_dram_ready = 0;
    end
    dram_dram_ready = 1;
    #1;
    chk("rd_no_9th_valid", rd_data_valid, 0);
    chk("rd_no_9th_fpu_rdy", dram_fpu_ready, 0);
    tick();
    dram_dram_ready = 0;
    chk("rd_beat_count", rd_beats - b0, 8);
    for (int i = 0; i < 8; i++) chk("rd_beat_data", rd_log[b0 + i], 64'hA000 + 64'(i));
    chk("rd_wait_done", rd_done, 0);
    dram_request_done = 1;
    tick();
    dram_request_done = 0;
    chk("rd_done_pulse", rd_done, 1);
    chk("rd_no_wr_done", wr_done, 0);
    rd_req = 0;
    tick();
    chk("rd_done_1cyc", rd_done, 0);
    chk("rd_grant_drop", rd_grant, 0);
    chk("rd_one_dram_req", dreq_cnt - d0, 1);

    // ---- single write, size 4, valid toggling then held high
    wr_req = 1; wr_addr = 32'h2000; wr_size = 4;
    tick();
    chk("wr_grant", wr_grant, 1);
    chk("wr_no_rd_grant", rd_grant, 0);
    chk("wr_rd_wr", dram_rd_wr, 1);
    chk("wr_req_size", dram_request_size, 4);
    chk("wr_dram_req", dram_request, 1);
    tick();
    dram_dram_ready = 1;
    acc = 0;
    w0 = wr_beats;
    for (int c = 0; c < 12; c++) begin
      wr_data_valid = (c < 8) ? (c % 2 == 1) : 1'b1;
      wr_data = 64'hB000 + 64'(c);
      #1;
      exp_rdy = wr_data_valid && (acc < 4);
      chk("wr_data_ready", wr_data_ready, exp_rdy);
      if (exp_rdy) begin
        chk("wr_write_data", dram_write_data, 64'hB000 + 64'(c));
        acc++;
      end
      tick();
    end
    chk("wr_rd_valid_quiet", rd_data_valid, 0);
    wr_data_valid = 0;
    dram_dram_ready = 0;
    chk("wr_beat_count", wr_beats - w0, 4);
    dram_request_done = 1;
    tick();
    dram_request_done = 0;
    chk("wr_done_pulse", wr_done, 1);
    wr_req = 0;
    tick();
    chk("wr_grant_drop", wr_grant, 0);

    // ---- both requesting, 3 bursts each: expect R W R W R W
    rd_req = 1; wr_req = 1; rd_size = 1; wr_size = 1;
    dram_dram_ready = 1; rd_data_ready = 1; wr_data_valid = 1; dram_request_done = 1;
    nr = 0; nw = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!(rd_grant || wr_grant) && n < 10) begin tick(); n++; end
      chk("rr_grant_timeout", (n < 10), 1);
      chk("rr_order_wr", wr_grant, (k % 2));
      n = 0;
      while (!(rd_done || wr_done) && n < 10) begin tick(); n++; end
      chk("rr_done_timeout", (n < 10), 1);
      chk("rr_done_side", rd_done, (k % 2 == 0));
      if (rd_done) begin nr++; if (nr == 3) rd_req = 0; end
      else begin nw++; if (nw == 3) wr_req = 0; end
      tick();
    end
    dram_dram_ready = 0; wr_data_valid = 0; dram_request_done = 0;
    chk("rr_no_overlap", overlap, 0);
    chk("rr_no_perr", protocol_err, 0);

    // ---- request_done coincident with last beat
    rd_req = 1; rd_size = 2;
    tick(); tick();
    dram_dram_ready = 1;
    tick();
    dram_request_done = 1;
    tick();
    dram_dram_ready = 0; dram_request_done = 0;
    chk("coinc_done", rd_done, 1);
    chk("coinc_no_perr", protocol_err, 0);
    rd_req = 0;
    tick();

    // ---- early request_done after beat 3 of 8
    rd_req = 1; rd_size = 8; rd_addr = 32'h3000;
    tick(); tick();
    b0 = rd_beats;
    for (int i = 0; i < 3; i++) begin
      dram_dram_ready = 1; tick();
      dram_dram_ready = 0; tick();
    end
    dram_request_done = 1;
    tick();
    dram_request_done = 0;
    chk("early_perr", protocol_err, 1);
    chk("early_no_done", rd_done, 0);
    chk("early_still_rdy", dram_fpu_ready, 1);
    for (int i = 3; i < 8; i++) begin
      chk("early_wait_done", rd_done, 0);
      dram_dram_ready = 1; tick();
    end
    dram_dram_ready = 0;
    chk("early_done_after_8", rd_done, 1);
    chk("early_beats", rd_beats - b0, 8);
    rd_req = 0;
    tick();
    chk("early_perr_sticky", protocol_err, 1);

    // ---- zero-length read
    d0 = dreq_cnt;
    rd_req = 1; rd_size = 0;
    tick();
    chk("zero_grant", rd_grant, 1);
    chk("zero_no_req", dram_request, 0);
    chk("zero_done_not_yet", rd_done, 0);
    tick();
    chk("zero_done", rd_done, 1);
    rd_req = 0;
    tick();
    chk("zero_done_1cyc", rd_done, 0);
    chk("zero_no_dram_req", dreq_cnt - d0, 0);

    // ---- reset mid-burst
    wr_req = 1; wr_size = 4; wr_addr = 32'h5000;
    dram_dram_ready = 1; wr_data_valid = 1;
    tick(); tick(); tick();
    wr_req = 0; rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_rst_wr_grant", wr_grant, 0);
    chk("mid_rst_addr", dram_address, 0);
    chk("mid_rst_size", dram_request_size, 0);
    chk("mid_rst_rd_wr", dram_rd_wr, 0);
    chk("mid_rst_perr", protocol_err, 0);
    chk("mid_rst_wr_ready", wr_data_ready, 0);
    chk("mid_rst_fpu_ready", dram_fpu_ready, 0);
    chk("mid_rst_wr_done", wr_done, 0);
    dram_dram_ready = 0; wr_data_valid = 0;
    tick();
    chk("mid_rst_no_done", wr_done, 0);
    rd_req = 1; rd_size = 1; rd_addr = 32'h4000;
    tick();
    chk("post_rst_grant", rd_grant, 1);
    chk("post_rst_addr", dram_address, 32'h4000);
    tick();
    dram_dram_ready = 1; dram_request_done = 1;
    tick();
    dram_dram_ready = 0; dram_request_done = 0;
    chk("post_rst_done", rd_done, 1);
    rd_req = 0;
    tick();

    chk("no_stray_done", stray_done, 0);
    chk("no_grant_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
